cmap_seq_ctrl: RTL and testbench

Sequencer for the Q8.8 logistic-map datapath x(n+1) = r*x*(1-x). Accepts a seed/parameter configuration and discards a programmable number of warm-up iterations. It then streams a programmed number of map samples over a valid/ready interface, advancing the map only on accepted samples. It detects degenerate fixed-point trajectories and terminates the run with a sticky flag.

---
 rtl/cmap_pkg.sv | 16 +
 rtl/cmap_seq_ctrl_if.sv | 38 +++
 rtl/cmap_step.sv | 33 +++
 rtl/cmap_seq_ctrl.sv | 143 ++++++++++++++
 tb/tb_cmap_seq_ctrl.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/cmap_pkg.sv
// Shared definitions for the logistic-map sequencer.
// Holds the Q8.8 constants, the default widths and the controller state type.
// It has no ports. It is imported by cmap_step and cmap_seq_ctrl.
package cmap_pkg;

    localparam int unsigned W_DEF      = 16;
    localparam int unsigned FRAC_DEF   = 8;
    localparam int unsigned WARM_W_DEF = 8;
    localparam int unsigned LEN_W_DEF  = 16;

    localparam logic [15:0] ONE  = 16'd256;
    localparam logic [15:0] HALF = 16'd128;

    typedef enum logic [1:0] {StIdle, StWarmup, StRun, StDone} state_e;

endpackage

// File: rtl/cmap_seq_ctrl_if.sv
// Configuration and sample-stream bundle for cmap_seq_ctrl.
// Configuration channel:
//   cfg_valid / cfg_ready handshake.
//   cfg_x0 is the seed and cfg_r is the map parameter, both Q8.8.
//   cfg_warmup is the number of discarded iterations.
//   cfg_len is the number of samples to emit; 0 means free-running.
// Sample channel:
//   out_valid / out_ready handshake.
//   out_data is the current x. out_bit is the x >= 0.5 bit.
// Modports:
//   master is the configuring source and the sample sink.
//   slave is the sequencer.
interface cmap_seq_ctrl_if #(
    parameter int unsigned W      = cmap_pkg::W_DEF,
    parameter int unsigned WARM_W = cmap_pkg::WARM_W_DEF,
    parameter int unsigned LEN_W  = cmap_pkg::LEN_W_DEF
);
    logic              cfg_valid;
    logic              cfg_ready;
    logic [W-1:0]      cfg_x0;
    logic [W-1:0]      cfg_r;
    logic [WARM_W-1:0] cfg_warmup;
    logic [LEN_W-1:0]  cfg_len;
    logic              out_valid;
    logic              out_ready;
    logic [W-1:0]      out_data;
    logic              out_bit;

    modport master (
        output cfg_valid, cfg_x0, cfg_r, cfg_warmup, cfg_len, out_ready,
        input  cfg_ready, out_valid, out_data, out_bit
    );

    modport slave (
        input  cfg_valid, cfg_x0, cfg_r, cfg_warmup, cfg_len, out_ready,
        output cfg_ready, out_valid, out_data, out_bit
    );
endinterface

// File: rtl/cmap_step.sv
// One iteration of the Q8.8 logistic map x' = r*x*(1-x). The logic is purely combinational.
// Ports:
//   i_x is the current x.
//   i_r is the map parameter.
//   o_x is the next x, saturated to the W-bit maximum.
module cmap_step
    import cmap_pkg::*;
#(
    parameter int unsigned W    = W_DEF,
    parameter int unsigned FRAC = FRAC_DEF
) (
    input  logic [W-1:0] i_x,
    input  logic [W-1:0] i_r,
    output logic [W-1:0] o_x
);
    localparam int unsigned PW = 2 * W;
    localparam int unsigned NW = PW + FRAC + 1;

    logic [FRAC:0] w_omx;
    logic [PW-1:0] w_rx;
    logic [PW-1:0] w_t;
    logic [NW-1:0] w_tx;
    logic [NW-1:0] w_n;

    // Modular 9-bit subtraction: a seed above 1.0 wraps rather than going negative.
    assign w_omx = ONE[FRAC:0] - i_x[FRAC:0];
    assign w_rx  = PW'(i_r) * PW'(i_x);
    assign w_t   = w_rx >> FRAC;
    assign w_tx  = NW'(w_t) * NW'(w_omx);
    assign w_n   = w_tx >> FRAC;
    assign o_x   = (|w_n[NW-1:W]) ? '1 : w_n[W-1:0];

endmodule

// File: rtl/cmap_seq_ctrl.sv
// Sequencer for the logistic-map datapath.
// It latches a configuration and discards the warm-up iterations.
// It then streams samples, advancing x only on accepted samples.
// Ports:
//   i_clk and i_rst_n are the clock and the async active-low reset.
//   bus carries the configuration and sample channels (slave side).
//   i_abort is a synchronous stop, honoured in WARMUP and RUN.
//   o_busy is high whenever the state is not IDLE.
//   o_done is a one-cycle pulse at the end of a run.
//   o_stuck is sticky: the trajectory reached a fixed point.
//   o_cfg_err is sticky: a seed above 1.0 was rejected.
module cmap_seq_ctrl
    import cmap_pkg::*;
#(
    parameter int unsigned W      = W_DEF,
    parameter int unsigned FRAC   = FRAC_DEF,
    parameter int unsigned WARM_W = WARM_W_DEF,
    parameter int unsigned LEN_W  = LEN_W_DEF
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    cmap_seq_ctrl_if.slave bus,
    input  logic           i_abort,
    output logic           o_busy,
    output logic           o_done,
    output logic           o_stuck,
    output logic           o_cfg_err
);
    state_e            r_state, w_state_nxt;
    logic [W-1:0]      r_x, w_x_nxt;
    logic [W-1:0]      r_r, w_r_nxt;
    logic [WARM_W-1:0] r_warm, w_warm_nxt;
    logic [LEN_W-1:0]  r_rem, w_rem_nxt;
    logic              r_stuck, w_stuck_nxt;
    logic              r_cfg_err, w_cfg_err_nxt;
    logic [W-1:0]      w_step;
    logic              w_fixed;

    cmap_step #(
        .W    (W),
        .FRAC (FRAC)
    ) u_step (
        .i_x (r_x),
        .i_r (r_r),
        .o_x (w_step)
    );

    assign w_fixed = (w_step == r_x);

    always_comb begin
        w_state_nxt   = r_state;
        w_x_nxt       = r_x;
        w_r_nxt       = r_r;
        w_warm_nxt    = r_warm;
        w_rem_nxt     = r_rem;
        w_stuck_nxt   = r_stuck;
        w_cfg_err_nxt = r_cfg_err;
        unique case (r_state)
            StIdle: begin
                if (bus.cfg_valid) begin
                    if (bus.cfg_x0 <= W'(ONE)) begin
                        w_x_nxt       = bus.cfg_x0;
                        w_r_nxt       = bus.cfg_r;
                        w_warm_nxt    = bus.cfg_warmup;
                        w_rem_nxt     = bus.cfg_len;
                        w_stuck_nxt   = 1'b0;
                        w_cfg_err_nxt = 1'b0;
                        w_state_nxt   = (bus.cfg_warmup != '0) ? StWarmup : StRun;
                    end else begin
                        w_cfg_err_nxt = 1'b1;
                    end
                end
            end
            StWarmup: begin
                w_x_nxt    = w_step;
                w_warm_nxt = r_warm - WARM_W'(1);
                if (w_fixed) begin
                    w_stuck_nxt = 1'b1;
                    w_state_nxt = StDone;
                end else if (i_abort) begin
                    w_state_nxt = StDone;
                end else if (r_warm == WARM_W'(1)) begin
                    w_state_nxt = StRun;
                end
            end
            StRun: begin
                if (bus.out_ready) begin
                    w_x_nxt = w_step;
                    // rem is zero only in free-running mode, so it is never decremented there.
                    if (r_rem != '0) begin
                        w_rem_nxt = r_rem - LEN_W'(1);
                    end
                    if (w_fixed) begin
                        w_stuck_nxt = 1'b1;
                        w_state_nxt = StDone;
                    end else if (r_rem == LEN_W'(1)) begin
                        w_state_nxt = StDone;
                    end
                end
                if (i_abort) begin
                    w_state_nxt = StDone;
                end
            end
            StDone: begin
                w_state_nxt = StIdle;
            end
            default: begin
                w_state_nxt = StIdle;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= StIdle;
            r_x       <= '0;
            r_r       <= '0;
            r_warm    <= '0;
            r_rem     <= '0;
            r_stuck   <= 1'b0;
            r_cfg_err <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_x       <= w_x_nxt;
            r_r       <= w_r_nxt;
            r_warm    <= w_warm_nxt;
            r_rem     <= w_rem_nxt;
            r_stuck   <= w_stuck_nxt;
            r_cfg_err <= w_cfg_err_nxt;
        end
    end

    assign bus.cfg_ready = (r_state == StIdle);
    assign bus.out_valid = (r_state == StRun);
    assign bus.out_data  = r_x;
    // HALF has only the x >= 0.5 bit set.
    assign bus.out_bit   = |(r_x & W'(HALF));
    assign o_busy        = (r_state != StIdle);
    assign o_done        = (r_state == StDone);
    assign o_stuck       = r_stuck;
    assign o_cfg_err     = r_cfg_err;

endmodule

// File: tb/tb_cmap_seq_ctrl.sv
// Self-checking bench for cmap_seq_ctrl.
// The reference model computes the map with plain integer arithmetic.
// It tracks warm-up count, delivered samples and the end-of-run rules per cycle.
module tb_cmap_seq_ctrl;
    logic clk = 1'b0;
    logic rst_n;
    logic abort;
    logic busy;
    logic done;
    logic stuck;
    logic cfg_err;

    int n_checks = 0;
    int n_fail   = 0;
    int got_q[$];

    cmap_seq_ctrl_if bus ();

    cmap_seq_ctrl dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .bus       (bus),
        .i_abort   (abort),
        .o_busy    (busy),
        .o_done    (done),
        .o_stuck   (stuck),
        .o_cfg_err (cfg_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic int step_m(input int x, input int r);
        longint omx, t, n;
        omx = longint'(256 - x) & 511;
        t   = (longint'(r) * longint'(x)) >> 8;
        n   = (t * omx) >> 8;
        if (n > 65535) n = 65535;
        return int'(n);
    endfunction

    // Called at a negedge. rmode selects out_ready: 0 always high, 1 pattern 1,0,0, 2 random.
    // abort_at is the cycle after the accept edge in which abort is held (-1: none).
    task automatic do_run(input int x0, input int r, input int warm, input int len,
                          input int rmode, input int abort_at);
        int  mx, nx, mwarm, nsamp, cyc, first_v;
        bit  in_run, ended, stuck_e, rdy;
        got_q.delete();
        bus.cfg_valid  = 1'b1;
        bus.cfg_x0     = 16'(x0);
        bus.cfg_r      = 16'(r);
        bus.cfg_warmup = 8'(warm);
        bus.cfg_len    = 16'(len);
        @(posedge clk);
        @(negedge clk);
        bus.cfg_valid = 1'b0;
        check("accept_busy", busy, 1);
        check("accept_cfg_ready", bus.cfg_ready, 0);
        check("accept_cfg_err", cfg_err, 0);
        check("accept_stuck", stuck, 0);
        mx = x0; mwarm = warm; in_run = (warm == 0);
        ended = 0; stuck_e = 0; nsamp = 0; first_v = -1; cyc = 1;
        while (!ended && cyc < 2000) begin
            abort = (cyc == abort_at);
            if (!in_run) begin
                check("warm_valid", bus.out_valid, 0);
                nx = step_m(mx, r);
                if (nx == mx) begin
                    stuck_e = 1; ended = 1;
                end
                if (abort) ended = 1;
                mx = nx;
                mwarm--;
                if (mwarm == 0) in_run = 1;
            end else begin
                if (first_v < 0) begin
                    first_v = cyc;
                    check("latency", cyc, warm + 1);
                end
                check("run_valid", bus.out_valid, 1);
                check("data", bus.out_data, mx);
                check("bit", bus.out_bit, (mx >> 7) & 1);
                case (rmode)
                    0:       rdy = 1'b1;
                    1:       rdy = ((cyc - first_v) % 3 == 0);
                    default: rdy = 1'($urandom_range(0, 1));
                endcase
                bus.out_ready = rdy;
                if (rdy) begin
                    got_q.push_back(mx);
                    nsamp++;
                    nx = step_m(mx, r);
                    if (nx == mx) begin
                        stuck_e = 1; ended = 1;
                    end
                    if (len != 0 && nsamp == len) ended = 1;
                    mx = nx;
                end
                if (abort) ended = 1;
            end
            if (!ended) begin
                @(negedge clk);
                cyc++;
            end
        end
        if (!ended) check("run_timeout", 0, 1);
        @(negedge clk);
        abort = 1'b0;
        bus.out_ready = 1'b0;
        check("done_pulse", done, 1);
        check("done_busy", busy, 1);
        check("done_valid", bus.out_valid, 0);
        check("stuck_flag", stuck, 32'(stuck_e));
        @(negedge clk);
        check("done_clear", done, 0);
        check("idle_busy", busy, 0);
        check("idle_cfg_ready", bus.cfg_ready, 1);
    endtask

    initial begin
        int x0, r, warm, len, ab;
        rst_n = 1'b1;
        abort = 1'b0;
        bus.cfg_valid = 1'b0; bus.cfg_x0 = '0; bus.cfg_r = '0;
        bus.cfg_warmup = '0; bus.cfg_len = '0; bus.out_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("rst_cfg_ready", bus.cfg_ready, 1);
        check("rst_valid", bus.out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_stuck", stuck, 0);
        check("rst_cfg_err", cfg_err, 0);
        check("rst_data", bus.out_data, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic run.
        do_run(128, 998, 0, 3, 0, -1);
        check("basic_count", got_q.size(), 3);
        if (got_q.size() == 3) begin
            check("basic_s0", got_q[0], 128);
            check("basic_s1", got_q[1], 249);
            check("basic_s2", got_q[2], 26);
        end

        // Warm-up of two iterations.
        do_run(128, 998, 2, 2, 0, -1);
        if (got_q.size() == 2) begin
            check("warm_s0", got_q[0], 26);
            check("warm_s1", got_q[1], 90);
        end else begin
            check("warm_count", got_q.size(), 2);
        end

        // Backpressure.
        do_run(128, 998, 0, 3, 1, -1);
        check("bp_count", got_q.size(), 3);
        if (got_q.size() == 3) check("bp_s2", got_q[2], 26);

        // Degenerate seeds.
        do_run(0, 998, 0, 0, 0, -1);
        check("seed0_count", got_q.size(), 1);
        do_run(256, 998, 0, 0, 0, -1);
        check("seed256_count", got_q.size(), 2);

        // Rejected seed.
        bus.cfg_valid = 1'b1;
        bus.cfg_x0    = 16'd300;
        @(posedge clk);
        @(negedge clk);
        bus.cfg_valid = 1'b0;
        check("rej_cfg_err", cfg_err, 1);
        check("rej_busy", busy, 0);
        check("rej_cfg_ready", bus.cfg_ready, 1);

        // Free-running run with abort.
        do_run(128, 998, 0, 0, 0, 4);
        check("abort_count", got_q.size(), 4);

        // Randomized runs.
        for (int i = 0; i < 14; i++) begin
            x0   = $urandom_range(0, 256);
            r    = $urandom_range(0, 1023);
            warm = $urandom_range(0, 6);
            len  = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 15);
            if (len == 0) ab = $urandom_range(1, 30);
            else ab = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 20) : -1;
            do_run(x0, r, warm, len, 2, ab);
        end

        // Async reset in the middle of warm-up.
        bus.cfg_valid  = 1'b1;
        bus.cfg_x0     = 16'd128;
        bus.cfg_r      = 16'd998;
        bus.cfg_warmup = 8'd50;
        bus.cfg_len    = 16'd4;
        @(posedge clk);
        @(negedge clk);
        bus.cfg_valid = 1'b0;
        check("pre_rst_busy", busy, 1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy", busy, 0);
        check("arst_cfg_ready", bus.cfg_ready, 1);
        check("arst_data", bus.out_data, 0);
        check("arst_valid", bus.out_valid, 0);
        check("arst_done", done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("arst_no_done", done, 0);
        end
        check("arst_idle", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
